// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : alu_pkg                                                      |
// | Description : Opcode constants, issuer FSM state encoding and a small      |
// |               helper shared by the ALU issuer and its sub-modules.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package alu_pkg;

    localparam logic [3:0] c_OP_ADD   = 4'b0000;
    localparam logic [3:0] c_OP_SHIFT = 4'b0011;
    localparam logic [3:0] c_OP_CRC   = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Only the ADD opcode carries a meaningful overflow flag from the ALU.
    function automatic logic op_reports_overflow(input logic [3:0] opcode);
        return (opcode == c_OP_ADD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issuer_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_issuer_timer                                             |
// | Description : Wait-cycle counter for the ALU issuer. Counts enabled        |
// |               cycles from zero and flags the cycle in which the count      |
// |               reaches TIMEOUT_CYC-1.                                       |
// | Ports       : clk     - clock, rising edge                                 |
// |               rst     - synchronous reset, active low                      |
// |               clear   - return the count to zero                           |
// |               enable  - count this cycle                                   |
// |               expired - enabled and count == TIMEOUT_CYC-1 (combinational) |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_issuer_timer #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int c_CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    logic [c_CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_LAST)) begin
            // Saturate at the last value; the issuer leaves WAIT on expiry anyway.
            r_count <= r_count + c_CNT_W'(1);
        end
    end

    assign expired = enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/alu_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_issuer                                                   |
// | Description : Single-outstanding command issuer for an external ALU.       |
// |               Accepts a command, presents it to the ALU for one cycle,     |
// |               waits for the result and returns it with the command tag.    |
// |               Define ALU_ISSUER_TIMEOUT_EN to build the wait timeout; when |
// |               undefined the issuer waits forever and rsp_timeout is 0.     |
// | Ports       : clk, rst (sync, active low)                                  |
// |               cmd_valid/cmd_ready, cmd_opcode/funct/a/b/tag   - command    |
// |               alu_valid_i, alu_opcode/funct/a/b               - to ALU     |
// |               alu_o, alu_valid_o, alu_overflow                - from ALU   |
// |               rsp_valid/rsp_ready, rsp_data/tag/overflow/timeout - response|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_issuer
    import alu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    // Command side
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_opcode,
    input  logic [2:0]        cmd_funct,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [TAG_W-1:0]  cmd_tag,
    // ALU drive
    output logic              alu_valid_i,
    output logic [3:0]        alu_opcode,
    output logic [2:0]        alu_funct,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    // ALU result
    input  logic [DATA_W-1:0] alu_o,
    input  logic              alu_valid_o,
    input  logic              alu_overflow,
    // Response side
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_overflow,
    output logic              rsp_timeout
);

    state_t              r_state;
    logic                r_cmd_ready;
    logic                r_alu_valid_i;
    logic [3:0]          r_opcode;
    logic [2:0]          r_funct;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [TAG_W-1:0]    r_tag;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic [TAG_W-1:0]    r_rsp_tag;
    logic                r_rsp_overflow;

    logic                w_capture;
    logic                w_timeout;
    logic                w_expired;

    // A result is only taken while a command is actually outstanding; results
    // arriving in IDLE or RESP are stale and dropped.
    assign w_capture = ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) && alu_valid_o;
    // A result in the expiry cycle wins over the timeout.
    assign w_timeout = (r_state == ST_WAIT) && !alu_valid_o && w_expired;

`ifdef ALU_ISSUER_TIMEOUT_EN
    logic r_rsp_timeout;
    logic w_timer_en;

    assign w_timer_en = (r_state == ST_WAIT);

    alu_issuer_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (!w_timer_en),
        .enable  (w_timer_en),
        .expired (w_expired)
    );

    assign rsp_timeout = r_rsp_timeout;
`else
    assign w_expired   = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_cmd_ready    <= 1'b0;
            r_alu_valid_i  <= 1'b0;
            r_opcode       <= '0;
            r_funct        <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_tag          <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_tag      <= '0;
            r_rsp_overflow <= 1'b0;
`ifdef ALU_ISSUER_TIMEOUT_EN
            r_rsp_timeout  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Ready is registered, so it first rises one cycle after
                    // reset release or after the response handshake.
                    r_cmd_ready <= 1'b1;
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready   <= 1'b0;
                        r_alu_valid_i <= 1'b1;
                        r_opcode      <= cmd_opcode;
                        r_funct       <= cmd_funct;
                        r_a           <= cmd_a;
                        r_b           <= cmd_b;
                        r_tag         <= cmd_tag;
                        r_state       <= ST_ISSUE;
                    end
                end

                ST_ISSUE, ST_WAIT: begin
                    // Operands stay registered; only the valid strobe drops.
                    r_alu_valid_i <= 1'b0;
                    if (w_capture) begin
                        r_rsp_valid    <= 1'b1;
                        r_rsp_data     <= alu_o;
                        r_rsp_tag      <= r_tag;
                        r_rsp_overflow <= op_reports_overflow(r_opcode) & alu_overflow;
`ifdef ALU_ISSUER_TIMEOUT_EN
                        r_rsp_timeout  <= 1'b0;
`endif
                        r_state        <= ST_RESP;
                    end else if (w_timeout) begin
                        r_rsp_valid    <= 1'b1;
                        r_rsp_data     <= '0;
                        r_rsp_tag      <= r_tag;
                        r_rsp_overflow <= 1'b0;
`ifdef ALU_ISSUER_TIMEOUT_EN
                        r_rsp_timeout  <= 1'b1;
`endif
                        r_state        <= ST_RESP;
                    end else begin
                        r_state        <= ST_WAIT;
                    end
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready    = r_cmd_ready;
    assign alu_valid_i  = r_alu_valid_i;
    assign alu_opcode   = r_opcode;
    assign alu_funct    = r_funct;
    assign alu_a        = r_a;
    assign alu_b        = r_b;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_tag      = r_rsp_tag;
    assign rsp_overflow = r_rsp_overflow;

endmodule
`default_nettype wire

// File: tb/tb_alu_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_issuer                                                |
// | Description : Scoreboard bench for alu_issuer. A driver issues commands    |
// |               and queues expected responses; a behavioural ALU answers     |
// |               after a chosen delay; a monitor checks every response.       |
// |               Timeout cases are built only with ALU_ISSUER_TIMEOUT_EN.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_issuer;

    localparam int TB_TO = 8;
`ifdef ALU_ISSUER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        int          d;
        bit          fake_ovf;
    } alu_job_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        bit          ovf;
        bit          to;
        int          stall;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [3:0]  cmd_opcode;
    logic [2:0]  cmd_funct;
    logic [31:0] cmd_a, cmd_b;
    logic [3:0]  cmd_tag;
    logic        alu_valid_i;
    logic [3:0]  alu_opcode;
    logic [2:0]  alu_funct;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_o;
    logic        alu_valid_o, alu_overflow;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic        rsp_overflow, rsp_timeout;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit alu_busy = 1'b0;

    alu_job_t job_q[$];
    exp_t     sb_q[$];
    int       acc_q[$];
    int       exp_cyc_q[$];

    alu_issuer #(
        .DATA_W      (32),
        .TAG_W       (4),
        .TIMEOUT_CYC (TB_TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_funct    (cmd_funct),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_tag      (cmd_tag),
        .alu_valid_i  (alu_valid_i),
        .alu_opcode   (alu_opcode),
        .alu_funct    (alu_funct),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_o        (alu_o),
        .alu_valid_o  (alu_valid_o),
        .alu_overflow (alu_overflow),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .rsp_tag      (rsp_tag),
        .rsp_overflow (rsp_overflow),
        .rsp_timeout  (rsp_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Behavioural ALU: the issuer just forwards whatever it returns.
    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a & b;
            4'b0011: return a << b[4:0];
            4'b1010: return {a[15:0], b[15:0]} ^ 32'h04C11DB7;
            default: return (op > 4'b1010) ? 32'hDEADBEEF : (a ^ b);
        endcase
    endfunction

    function automatic bit add_ovf(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        s = a + b;
        return (a[31] == b[31]) && (s[31] != a[31]);
    endfunction

    // Driver: one command; expected response is queued at issue time.
    task automatic issue(input logic [3:0] op, input logic [2:0] funct, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag, input int d,
                         input bit fake_ovf, input int stall, input bit expect_rsp);
        alu_job_t j;
        exp_t     e;
        int       n;
        bit       to;
        n = 0;
        @(negedge clk);
        while ((alu_busy || cmd_ready !== 1'b1) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) fail("cmd_ready_wait_expired");
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_funct  = funct;
        cmd_a      = a;
        cmd_b      = b;
        cmd_tag    = tag;
        j.op = op; j.funct = funct; j.a = a; j.b = b; j.d = d; j.fake_ovf = fake_ovf;
        job_q.push_back(j);
        acc_q.push_back(cyc);
        if (expect_rsp) begin
            to      = TO_EN && (d > TB_TO);
            e.data  = to ? 32'h0 : alu_fn(op, a, b);
            e.tag   = tag;
            e.ovf   = !to && (op == 4'b0000) && add_ovf(a, b);
            e.to    = to;
            e.stall = stall;
            sb_q.push_back(e);
        end
        @(negedge clk);
        cmd_valid  = 1'b0;
        cmd_opcode = 4'($urandom);
        cmd_a      = $urandom;
        cmd_b      = $urandom;
    endtask

    // ALU responder: checks the issue strobe and operand hold, then answers.
    initial begin
        alu_job_t job;
        bit       aborted;
        alu_valid_o  = 1'b0;
        alu_o        = '0;
        alu_overflow = 1'b0;
        forever begin
            @(negedge clk);
            alu_valid_o  = 1'b0;
            alu_o        = $urandom;
            alu_overflow = 1'($urandom_range(0, 1));
            if (rst === 1'b1 && alu_valid_i === 1'b1) begin
                if (job_q.size() == 0) begin
                    fail("alu_valid_i_without_command");
                    continue;
                end
                job      = job_q.pop_front();
                alu_busy = 1'b1;
                aborted  = 1'b0;
                chk("issue_latency", 64'(cyc), 64'(acc_q.pop_front() + 1));
                for (int k = 0; k <= job.d; k++) begin
                    if (k > 0) begin
                        @(negedge clk);
                        alu_o = $urandom;
                        if (rst !== 1'b1) aborted = 1'b1;
                        if (!aborted) chk("alu_valid_i_single_pulse", 64'(alu_valid_i), 64'd0);
                    end
                    if (!aborted) begin
                        chk("alu_opcode_held", 64'(alu_opcode), 64'(job.op));
                        chk("alu_funct_held",  64'(alu_funct),  64'(job.funct));
                        chk("alu_a_held",      64'(alu_a),      64'(job.a));
                        chk("alu_b_held",      64'(alu_b),      64'(job.b));
                    end
                    if (k == job.d) begin
                        alu_valid_o  = 1'b1;
                        alu_o        = alu_fn(job.op, job.a, job.b);
                        alu_overflow = (job.op == 4'b0000) ? add_ovf(job.a, job.b) : job.fake_ovf;
                        if (!aborted && !(TO_EN && job.d > TB_TO)) exp_cyc_q.push_back(cyc + 1);
                    end else if (TO_EN && !aborted && k == TB_TO && job.d > TB_TO) begin
                        exp_cyc_q.push_back(cyc + 1);
                    end
                end
                alu_busy = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on each new response and checks hold/backpressure.
    initial begin
        exp_t cur;
        int   stall_left;
        bit   holding;
        bit   expect_idle;
        stall_left  = 0;
        holding     = 1'b0;
        expect_idle = 1'b0;
        rsp_ready   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                holding     = 1'b0;
                expect_idle = 1'b0;
                rsp_ready   = 1'b0;
                continue;
            end
            if (expect_idle) begin
                chk("cmd_ready_after_handshake", 64'(cmd_ready), 64'd1);
                chk("rsp_valid_after_handshake", 64'(rsp_valid), 64'd0);
                expect_idle = 1'b0;
            end
            if (rsp_valid === 1'b1) begin
                if (!holding) begin
                    if (sb_q.size() == 0) begin
                        fail("unexpected_rsp_valid");
                        rsp_ready = 1'b1;
                        continue;
                    end
                    cur = sb_q.pop_front();
                    if (exp_cyc_q.size() == 0) fail("rsp_latency_unexpected");
                    else chk("rsp_latency", 64'(cyc), 64'(exp_cyc_q.pop_front()));
                    chk("rsp_data",     64'(rsp_data),     64'(cur.data));
                    chk("rsp_tag",      64'(rsp_tag),      64'(cur.tag));
                    chk("rsp_overflow", 64'(rsp_overflow), 64'(cur.ovf));
                    chk("rsp_timeout",  64'(rsp_timeout),  64'(cur.to));
                    stall_left = cur.stall;
                    holding    = 1'b1;
                end else begin
                    chk("rsp_data_stable",     64'(rsp_data),     64'(cur.data));
                    chk("rsp_tag_stable",      64'(rsp_tag),      64'(cur.tag));
                    chk("rsp_overflow_stable", 64'(rsp_overflow), 64'(cur.ovf));
                    chk("rsp_timeout_stable",  64'(rsp_timeout),  64'(cur.to));
                    chk("cmd_ready_low_in_resp", 64'(cmd_ready),  64'd0);
                end
                if (stall_left == 0) begin
                    rsp_ready   = 1'b1;
                    holding     = 1'b0;
                    expect_idle = 1'b1;
                end else begin
                    rsp_ready = 1'b0;
                    stall_left--;
                end
            end else begin
                if (holding) fail("rsp_valid_dropped_before_handshake");
                holding   = 1'b0;
                rsp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    // Main sequence.
    initial begin
        int n;
        int d;
        rst        = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_funct  = '0;
        cmd_a      = '0;
        cmd_b      = '0;
        cmd_tag    = '0;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready",    64'(cmd_ready),    64'd0);
        chk("reset_alu_valid_i",  64'(alu_valid_i),  64'd0);
        chk("reset_alu_opcode",   64'(alu_opcode),   64'd0);
        chk("reset_alu_funct",    64'(alu_funct),    64'd0);
        chk("reset_alu_a",        64'(alu_a),        64'd0);
        chk("reset_alu_b",        64'(alu_b),        64'd0);
        chk("reset_rsp_valid",    64'(rsp_valid),    64'd0);
        chk("reset_rsp_data",     64'(rsp_data),     64'd0);
        chk("reset_rsp_tag",      64'(rsp_tag),      64'd0);
        chk("reset_rsp_overflow", 64'(rsp_overflow), 64'd0);
        chk("reset_rsp_timeout",  64'(rsp_timeout),  64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

        // Directed cases.
        issue(4'b0000, 3'd0, 32'd5,          32'd7,          4'd3, 0, 1'b0, 0,  1'b1);
        issue(4'b0000, 3'd1, 32'h7FFFFFFF,   32'd1,          4'd5, 0, 1'b0, 0,  1'b1);
        issue(4'b0010, 3'd2, 32'hFFFF0000,   32'h0F0F0F0F,   4'd6, 0, 1'b1, 1,  1'b1);
        issue(4'b0011, 3'd3, 32'h00000001,   32'd4,          4'd7, 5, 1'b0, 0,  1'b1);
        issue(4'b1111, 3'd7, 32'h12345678,   32'h9ABCDEF0,   4'd8, 2, 1'b1, 0,  1'b1);
        issue(4'b0000, 3'd0, 32'd1,          32'd2,          4'd9, 3, 1'b0, 10, 1'b1);
        if (TO_EN) begin
            issue(4'b0001, 3'd0, 32'd100, 32'd1, 4'd10, TB_TO,     1'b0, 0, 1'b1);
            issue(4'b0000, 3'd0, 32'd3,   32'd4, 4'd11, TB_TO + 1, 1'b0, 0, 1'b1);
            issue(4'b0011, 3'd1, 32'd3,   32'd2, 4'd12, TB_TO + 4, 1'b1, 2, 1'b1);
        end

        // Randomized cases.
        for (int i = 0; i < 60; i++) begin
            d = TO_EN ? int'($urandom_range(0, TB_TO + 3)) : int'($urandom_range(0, 6));
            issue(4'($urandom), 3'($urandom),
                  ($urandom_range(0, 3) == 0) ? 32'h7FFFFFFF : 32'($urandom),
                  ($urandom_range(0, 3) == 0) ? 32'h00000001 : 32'($urandom),
                  4'($urandom), d, 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)), 1'b1);
        end

        // Reset while waiting; the late ALU result must be ignored.
        issue(4'b0011, 3'd0, 32'hA5A5A5A5, 32'd3, 4'd2, 5, 1'b0, 0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("cmd_ready_low_in_reset", 64'(cmd_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_wait_reset", 64'(cmd_ready), 64'd1);
        for (int k = 0; k < 4; k++) begin
            chk("no_rsp_after_reset", 64'(rsp_valid), 64'd0);
            @(negedge clk);
        end

        // One more command to show the issuer is usable after the abort.
        issue(4'b0000, 3'd0, 32'd40, 32'd2, 4'd15, 1, 1'b0, 0, 1'b1);

        n = 0;
        while ((sb_q.size() != 0 || alu_busy) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) fail("drain_expired");
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/alu_issuer.md
ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter TAG_W, default 4, command tag width.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 64, max cycles waiting for ALU result.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-007 SHALL have cmd_opcode  cmd_funct  cmd_a  cmd_b  cmd_tag  input  4/3/DATA_W/DATA_W/TAG_W  command fields.
REQ-008 SHALL have alu_valid_i  alu_opcode  alu_funct  alu_a  alu_b  output  1/4/3/DATA_W/DATA_W  drive to ALU.
REQ-009 SHALL have alu_o  alu_valid_o  alu_overflow  input  DATA_W/1/1  ALU result side.
REQ-010 SHALL have rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-011 SHALL have rsp_data  rsp_tag  rsp_overflow  rsp_timeout  output  DATA_W/TAG_W/1/1  response fields.

Function
REQ-012 SHALL implement FSM IDLE, ISSUE, WAIT, RESP; one command in flight.
REQ-013 SHALL assert cmd_ready only in IDLE; cmd_valid&cmd_ready registers all cmd fields, next state ISSUE.
REQ-014 SHALL in ISSUE assert alu_valid_i for exactly one cycle with registered opcode/funct/a/b.
REQ-015 SHALL hold alu_opcode/funct/a/b stable from ISSUE until result capture; alu_valid_i low in WAIT.
REQ-016 SHALL, if alu_valid_o=1 in ISSUE, capture alu_o and go RESP (combinational ops: rsp_valid 2 cycles after cmd accept).
REQ-017 SHALL otherwise enter WAIT, capture alu_o on first alu_valid_o=1 cycle, go RESP next cycle.
REQ-018 SHALL set rsp_overflow = alu_overflow at capture only when opcode==4'b0000, else 0.
REQ-019 SHALL hold rsp_valid and all rsp fields stable in RESP until rsp_ready; then IDLE next cycle.
REQ-020 SHALL ignore alu_valid_o in IDLE and RESP (stale/late results dropped).
REQ-021 SHALL forward opcodes >4'b1010 unchanged and return whatever alu_o is (e.g. 32'hDEADBEEF).
REQ-022 SHALL, with timeout enabled, count WAIT cycles from 0; at count==TIMEOUT_CYC-1 without alu_valid_o go RESP with rsp_data=0, rsp_timeout=1.
REQ-023 SHALL give alu_valid_o priority over timeout when both occur in the same cycle (rsp_timeout=0).

Reset
REQ-024 SHALL on rst=0 at a clock edge force IDLE from any state, discarding in-flight command.
REQ-025 SHALL reset cmd_ready=0 during reset, alu_valid_i=0, alu_opcode/funct/a/b=0, rsp_valid=0, rsp_data/tag/overflow/timeout=0, timeout counter=0.
REQ-026 SHALL raise cmd_ready the first cycle after rst returns to 1.

Configuration
REQ-027 SHALL compile timeout logic only when macro ALU_ISSUER_TIMEOUT_EN is defined.
REQ-028 SHALL, without ALU_ISSUER_TIMEOUT_EN, remain in WAIT indefinitely and tie rsp_timeout to 0.

Structure
REQ-029 SHALL take opcode constants (ADD=4'b0000, SHIFT=4'b0011, CRC=4'b1010) and FSM state enum from shared package alu_pkg.
REQ-030 SHALL place timeout counter in sub-module alu_issuer_timer (clear, enable, expired) instantiated only under the macro.

Verification
REQ-031 SHALL cover ADD a=5 b=7 tag=3, ALU combinational -> rsp_valid 2 cycles after accept, rsp_data=12, rsp_tag=3, rsp_overflow=0.
REQ-032 SHALL cover ADD a=32'h7FFFFFFF b=1, alu_overflow=1 -> rsp_data=32'h80000000, rsp_overflow=1; logic op with alu_overflow=1 -> rsp_overflow=0.
REQ-033 SHALL cover SHIFT with alu_valid_o 5 cycles after ISSUE -> operands held stable throughout, rsp_valid 1 cycle after alu_valid_o.
REQ-034 SHALL cover rsp_ready low 10 cycles -> rsp fields stable, cmd_ready=0 until 1 cycle after handshake.
REQ-035 SHALL cover (macro on, TIMEOUT_CYC=8) no alu_valid_o -> rsp_timeout=1, rsp_data=0 after 8 WAIT cycles; alu_valid_o on 8th cycle -> normal response.
REQ-036 SHALL cover rst=0 in WAIT then late alu_valid_o in IDLE -> no rsp_valid, cmd_ready=1 after reset release.
